// File: rtl/fetch_exc_ctrl_pkg.sv
// ctrl_pkg: state encodings, ALU/mux codes, opcode/funct constants and cause codes for fetch_exc_ctrl.
// The EXC_* states exist only when FETCH_EXC_CTRL_EXC_EN is defined.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_FETCH    = 3'd1,
    ST_MEMWAIT  = 3'd2,
    ST_DECODE   = 3'd3,
    ST_EXEC     = 3'd4
`ifdef FETCH_EXC_CTRL_EXC_EN
    , ST_EXC_SAVE = 3'd5,
    ST_EXC_MEM  = 3'd6,
    ST_EXC_LOAD = 3'd7
`endif
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [1:0] CAUSE_ILL  = 2'b00;
  localparam logic [1:0] CAUSE_OVF  = 2'b01;
  localparam logic [1:0] CAUSE_DIV0 = 2'b10;

  localparam logic [1:0] MEM_SEL_PC     = 2'b00;
  localparam logic [1:0] MEM_SEL_EXC    = 2'b10;
  localparam logic [1:0] PC_SEL_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_SEL_EXC     = 2'b11;
  localparam logic [1:0] SRCA_PC        = 2'b00;
  localparam logic [1:0] SRCB_FOUR      = 2'b01;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_DIV = 6'h1A;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic       reset_out;
    logic       PC_w;
    logic       IR_w;
    logic       MEM_w;
    logic       ALUOut_w;
    logic       EPC_w;
    logic [1:0] Mux_MEM;
    logic [1:0] Mux_PC;
    logic [1:0] Mux_ALUSrcA;
    logic [1:0] Mux_ALUSrcB;
    logic [1:0] Mux_EXC;
    logic [3:0] ALUOp;
    logic       exec_start;
  } ctrl_out_t;

  localparam ctrl_out_t OUT_IDLE  = '0;
  localparam ctrl_out_t OUT_RESET = '{reset_out: 1'b1, default: '0};
  // FETCH computes PC+4 into ALUOut; DECODE then commits it through the same PC mux leg.
  localparam ctrl_out_t OUT_FETCH = '{ALUOut_w: 1'b1, Mux_MEM: MEM_SEL_PC, Mux_PC: PC_SEL_ALUOUT,
                                      Mux_ALUSrcA: SRCA_PC, Mux_ALUSrcB: SRCB_FOUR,
                                      ALUOp: ALU_ADD, default: '0};
  localparam ctrl_out_t OUT_DECODE = '{PC_w: 1'b1, Mux_PC: PC_SEL_ALUOUT, default: '0};
  localparam ctrl_out_t OUT_EXC_SAVE = '{EPC_w: 1'b1, Mux_ALUSrcA: SRCA_PC, Mux_ALUSrcB: SRCB_FOUR,
                                         ALUOp: ALU_SUB, default: '0};
  localparam ctrl_out_t OUT_EXC_LOAD = '{PC_w: 1'b1, Mux_PC: PC_SEL_EXC, default: '0};

endpackage

// File: rtl/fetch_exc_ctrl_if.sv
// fetch_exc_ctrl_if: controller <-> datapath/execution-unit signal bundle (master = controller).
interface fetch_exc_ctrl_if #(
  parameter int OPC_W = 6
);
  import ctrl_pkg::*;

  // Launch handshake: exec_start pulses for exactly one cycle on EXEC entry while exec_op
  // holds {opcode,funct}; the execution unit answers with a one-cycle exec_done pulse, which
  // is only honoured while the controller is in EXEC (any other cycle it is ignored).
  logic [OPC_W-1:0]   opcode;
  logic [OPC_W-1:0]   funct;
  logic               exec_done;
  logic               ovf;
  logic               div0;

  logic               reset_out;
  logic               PC_w;
  logic               IR_w;
  logic               MEM_w;
  logic               ALUOut_w;
  logic               EPC_w;
  logic [1:0]         Mux_MEM;
  logic [1:0]         Mux_PC;
  logic [1:0]         Mux_ALUSrcA;
  logic [1:0]         Mux_ALUSrcB;
  logic [1:0]         Mux_EXC;
  logic [3:0]         ALUOp;
  logic               exec_start;
  logic [2*OPC_W-1:0] exec_op;
  state_t             state;

  modport master (
    input  opcode, funct, exec_done, ovf, div0,
    output reset_out, PC_w, IR_w, MEM_w, ALUOut_w, EPC_w,
           Mux_MEM, Mux_PC, Mux_ALUSrcA, Mux_ALUSrcB, Mux_EXC,
           ALUOp, exec_start, exec_op, state
  );

  modport slave (
    output opcode, funct, exec_done, ovf, div0,
    input  reset_out, PC_w, IR_w, MEM_w, ALUOut_w, EPC_w,
           Mux_MEM, Mux_PC, Mux_ALUSrcA, Mux_ALUSrcB, Mux_EXC,
           ALUOp, exec_start, exec_op, state
  );
endinterface

// File: rtl/fetch_exc_ctrl_op_legal_dec.sv
// op_legal_dec: combinational legality check of an {opcode,funct} pair.
module op_legal_dec
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [OPC_W-1:0] funct,
  output logic             legal
);
  // funct only qualifies R-type; every other listed opcode is legal whatever funct holds.
  always_comb begin
    legal = 1'b0;
    if (opcode == OPC_W'(OP_RTYPE)) begin
      legal = funct inside {OPC_W'(FN_ADD), OPC_W'(FN_SUB), OPC_W'(FN_AND),
                            OPC_W'(FN_OR), OPC_W'(FN_SLT), OPC_W'(FN_DIV)};
    end else begin
      legal = opcode inside {OPC_W'(OP_J), OPC_W'(OP_BEQ), OPC_W'(OP_ADDI),
                             OPC_W'(OP_LW), OPC_W'(OP_SW)};
    end
  end
endmodule

// File: rtl/fetch_exc_ctrl.sv
// fetch_exc_ctrl: multi-cycle fetch/decode/launch controller with optional exception sequencing.
// Define FETCH_EXC_CTRL_EXC_EN to build the EXC_SAVE/EXC_MEM/EXC_LOAD path.
module fetch_exc_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int OPC_W   = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  fetch_exc_ctrl_if.master bus
);
  localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

  state_t             state;
  logic [2:0]         wait_cnt;
  ctrl_out_t          outs;
  logic [2*OPC_W-1:0] exec_op_q;
  logic               legal;
`ifdef FETCH_EXC_CTRL_EXC_EN
  logic [1:0]         cause;
`else
  logic               unused_flags;
  assign unused_flags = bus.ovf ^ bus.div0;
`endif

  op_legal_dec #(.OPC_W(OPC_W)) u_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .legal  (legal)
  );

  // Outputs are registered alongside the state: each branch loads the values for the state it enters.
  always_ff @(posedge clk) begin
    outs <= OUT_IDLE;
    if (reset_in) begin
      state     <= ST_RESET;
      outs      <= OUT_RESET;
      wait_cnt  <= '0;
      exec_op_q <= '0;
`ifdef FETCH_EXC_CTRL_EXC_EN
      cause     <= CAUSE_ILL;
`endif
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_FETCH;
          outs  <= OUT_FETCH;
        end
        ST_FETCH: begin
          state       <= ST_MEMWAIT;
          wait_cnt    <= '0;
          outs.IR_w   <= (LAST_WAIT == 3'd0);
        end
        ST_MEMWAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state <= ST_DECODE;
            outs  <= OUT_DECODE;
          end else begin
            wait_cnt  <= wait_cnt + 3'd1;
            outs.IR_w <= (wait_cnt + 3'd1 == LAST_WAIT);
          end
        end
        ST_DECODE: begin
          if (legal) begin
            state           <= ST_EXEC;
            outs.exec_start <= 1'b1;
            exec_op_q       <= {bus.opcode, bus.funct};
          end else begin
`ifdef FETCH_EXC_CTRL_EXC_EN
            state <= ST_EXC_SAVE;
            cause <= CAUSE_ILL;
            outs  <= OUT_EXC_SAVE;
`else
            state <= ST_FETCH;
            outs  <= OUT_FETCH;
`endif
          end
        end
        ST_EXEC: begin
          // A fault flag outranks a same-cycle exec_done; div0 outranks ovf.
`ifdef FETCH_EXC_CTRL_EXC_EN
          if (bus.div0 || bus.ovf) begin
            state     <= ST_EXC_SAVE;
            cause     <= bus.div0 ? CAUSE_DIV0 : CAUSE_OVF;
            outs      <= OUT_EXC_SAVE;
            exec_op_q <= '0;
          end else
`endif
          if (bus.exec_done) begin
            state     <= ST_FETCH;
            outs      <= OUT_FETCH;
            exec_op_q <= '0;
          end
        end
`ifdef FETCH_EXC_CTRL_EXC_EN
        ST_EXC_SAVE: begin
          state        <= ST_EXC_MEM;
          wait_cnt     <= '0;
          outs.Mux_MEM <= MEM_SEL_EXC;
          outs.Mux_EXC <= cause;
        end
        ST_EXC_MEM: begin
          if (wait_cnt == LAST_WAIT) begin
            state <= ST_EXC_LOAD;
            outs  <= OUT_EXC_LOAD;
          end else begin
            wait_cnt     <= wait_cnt + 3'd1;
            outs.Mux_MEM <= MEM_SEL_EXC;
            outs.Mux_EXC <= cause;
          end
        end
        ST_EXC_LOAD: begin
          state <= ST_FETCH;
          outs  <= OUT_FETCH;
        end
`endif
        default: begin
          state <= ST_RESET;
          outs  <= OUT_RESET;
        end
      endcase
    end
  end

  assign bus.reset_out   = outs.reset_out;
  assign bus.PC_w        = outs.PC_w;
  assign bus.IR_w        = outs.IR_w;
  assign bus.MEM_w       = outs.MEM_w;
  assign bus.ALUOut_w    = outs.ALUOut_w;
  assign bus.EPC_w       = outs.EPC_w;
  assign bus.Mux_MEM     = outs.Mux_MEM;
  assign bus.Mux_PC      = outs.Mux_PC;
  assign bus.Mux_ALUSrcA = outs.Mux_ALUSrcA;
  assign bus.Mux_ALUSrcB = outs.Mux_ALUSrcB;
  assign bus.Mux_EXC     = outs.Mux_EXC;
  assign bus.ALUOp       = outs.ALUOp;
  assign bus.exec_start  = outs.exec_start;
  assign bus.exec_op     = exec_op_q;
  assign bus.state       = state;
endmodule

// File: tb/tb_fetch_exc_ctrl.sv
// tb_fetch_exc_ctrl: cycle-by-cycle vector bench for fetch_exc_ctrl at MEM_LAT=1 (u1) and MEM_LAT=3 (u3).
module tb_fetch_exc_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       exec_done = 1'b0;
  logic       ovf = 1'b0;
  logic       div0 = 1'b0;

  fetch_exc_ctrl_if #(.OPC_W(6)) if1 ();
  fetch_exc_ctrl_if #(.OPC_W(6)) if3 ();

  assign if1.opcode = opcode;    assign if3.opcode = opcode;
  assign if1.funct = funct;      assign if3.funct = funct;
  assign if1.exec_done = exec_done; assign if3.exec_done = exec_done;
  assign if1.ovf = ovf;          assign if3.ovf = ovf;
  assign if1.div0 = div0;        assign if3.div0 = div0;

  fetch_exc_ctrl #(.MEM_LAT(1), .OPC_W(6)) u1 (.clk(clk), .reset_in(rst), .bus(if1));
  fetch_exc_ctrl #(.MEM_LAT(3), .OPC_W(6)) u3 (.clk(clk), .reset_in(rst), .bus(if3));

  logic [32:0] act1, act3;
  assign act1 = {if1.reset_out, if1.PC_w, if1.IR_w, if1.MEM_w, if1.ALUOut_w, if1.EPC_w,
                 if1.Mux_MEM, if1.Mux_PC, if1.Mux_ALUSrcA, if1.Mux_ALUSrcB, if1.Mux_EXC,
                 if1.ALUOp, if1.exec_start, if1.exec_op};
  assign act3 = {if3.reset_out, if3.PC_w, if3.IR_w, if3.MEM_w, if3.ALUOut_w, if3.EPC_w,
                 if3.Mux_MEM, if3.Mux_PC, if3.Mux_ALUSrcA, if3.Mux_ALUSrcB, if3.Mux_EXC,
                 if3.ALUOp, if3.exec_start, if3.exec_op};

  // ---------------- vector table + scoreboard ----------------
  typedef struct {
    logic        sel;
    logic        rst;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        done;
    logic        ovf;
    logic        div0;
    logic [32:0] exp;
    logic [63:0] tag;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [32:0] mk(input logic ro, pcw, irw, aluw, epcw,
                                     input logic [1:0] mm, mp, sa, sb, mx,
                                     input logic [3:0] op, input logic st,
                                     input logic [11:0] xo);
    return {ro, pcw, irw, 1'b0, aluw, epcw, mm, mp, sa, sb, mx, op, st, xo};
  endfunction

  logic [32:0] e_rst, e_fetch, e_wait, e_wait_ir, e_dec, e_save, e_load;

  function automatic logic [32:0] e_ex1(input logic [11:0] xo);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1, xo);
  endfunction
  function automatic logic [32:0] e_ex(input logic [11:0] xo);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, xo);
  endfunction
  function automatic logic [32:0] e_emem(input logic [1:0] c);
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, c, 4'b0000, 0, 12'h000);
  endfunction

  task automatic add(input logic sel, r, input logic [5:0] o, f, input logic d, v, z,
                     input logic [32:0] e, input logic [63:0] t);
    vec_t x;
    x.sel = sel; x.rst = r; x.opc = o; x.fn = f;
    x.done = d; x.ovf = v; x.div0 = z; x.exp = e; x.tag = t;
    vecs.push_back(x);
  endtask

  task automatic go(input logic sel, input logic [5:0] o, f, input logic [32:0] e, input logic [63:0] t);
    add(sel, 1'b0, o, f, 1'b0, 1'b0, 1'b0, e, t);
  endtask

  task automatic chk(input logic [32:0] g, input logic [32:0] w, input logic [63:0] t);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %0s got=%h want=%h", t, g, w);
    end
  endtask

  logic [5:0]  fa, fi;
  logic [32:0] got, want;

  initial begin
    e_rst     = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 12'h000);
    e_fetch   = mk(0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0001, 0, 12'h000);
    e_wait    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 12'h000);
    e_wait_ir = mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 12'h000);
    e_dec     = mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 12'h000);
    e_save    = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0010, 0, 12'h000);
    e_load    = mk(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 12'h000);
    fa = 6'($urandom_range(0, 63));
    fi = 6'($urandom_range(0, 63));

    // u1: reset, then ADD R-type; stray exec_done/ovf during reset and MEMWAIT are ignored
    add(0, 1, 6'h00, 6'h20, 0, 0, 0, e_rst, "rst");
    add(0, 1, 6'h00, 6'h20, 1, 1, 1, e_rst, "rst_in");
    go (0, 6'h00, 6'h20, e_fetch, "fetch");
    add(0, 0, 6'h00, 6'h20, 1, 1, 0, e_wait_ir, "ir_w");
    go (0, 6'h00, 6'h20, e_dec, "dec");
    go (0, 6'h00, 6'h20, e_ex1(12'h020), "start");
    go (0, 6'h00, 6'h20, e_ex(12'h020), "exec");
    add(0, 0, 6'h00, 6'h20, 1, 0, 0, e_fetch, "ret");
    // SUB with exec_done right after launch
    go (0, 6'h00, 6'h22, e_wait_ir, "ir_sub");
    go (0, 6'h00, 6'h22, e_dec, "dec_sub");
    go (0, 6'h00, 6'h22, e_ex1(12'h022), "st_sub");
    add(0, 0, 6'h00, 6'h22, 1, 0, 0, e_fetch, "ret_sub");
    // illegal opcode 3D
    go (0, 6'h3D, fi, e_wait_ir, "ir_ill");
    go (0, 6'h3D, fi, e_dec, "dec_ill");
`ifdef FETCH_EXC_CTRL_EXC_EN
    go (0, 6'h3D, fi, e_save, "sv_ill");
    add(0, 0, 6'h3D, fi, 1, 1, 1, e_emem(2'b00), "em_ill");
    add(0, 0, 6'h3D, fi, 1, 1, 1, e_load, "ld_ill");
    go (0, 6'h3D, fi, e_fetch, "f_ill");
    // ADDI overflow -> cause 01
    go (0, 6'h08, fa, e_wait_ir, "ir_ovf");
    go (0, 6'h08, fa, e_dec, "dec_ovf");
    go (0, 6'h08, fa, e_ex1({6'h08, fa}), "st_ovf");
    add(0, 0, 6'h08, fa, 0, 1, 0, e_save, "sv_ovf");
    go (0, 6'h08, fa, e_emem(2'b01), "em_ovf");
    go (0, 6'h08, fa, e_load, "ld_ovf");
    go (0, 6'h08, fa, e_fetch, "f_ovf");
    // ovf, div0 and exec_done together -> cause 10, no early FETCH
    go (0, 6'h00, 6'h1A, e_wait_ir, "ir_dz");
    go (0, 6'h00, 6'h1A, e_dec, "dec_dz");
    go (0, 6'h00, 6'h1A, e_ex1(12'h01A), "st_dz");
    add(0, 0, 6'h00, 6'h1A, 1, 1, 1, e_save, "sv_dz");
    go (0, 6'h00, 6'h1A, e_emem(2'b10), "em_dz");
    go (0, 6'h00, 6'h1A, e_load, "ld_dz");
    go (0, 6'h00, 6'h1A, e_fetch, "f_dz");
    // reset pulse while in EXC_MEM
    go (0, 6'h3D, fi, e_wait_ir, "ir_r");
    go (0, 6'h3D, fi, e_dec, "dec_r");
    go (0, 6'h3D, fi, e_save, "sv_r");
    go (0, 6'h3D, fi, e_emem(2'b00), "em_r");
    add(0, 1, 6'h3D, fi, 0, 0, 0, e_rst, "rst_em");
    go (0, 6'h3D, fi, e_fetch, "f_rem");
`else
    go (0, 6'h3D, fi, e_fetch, "f_ill");
    // ovf/div0 have no effect without the exception path
    go (0, 6'h08, fa, e_wait_ir, "ir_ovf");
    go (0, 6'h08, fa, e_dec, "dec_ovf");
    go (0, 6'h08, fa, e_ex1({6'h08, fa}), "st_ovf");
    add(0, 0, 6'h08, fa, 0, 1, 1, e_ex({6'h08, fa}), "ign_ovf");
    add(0, 0, 6'h08, fa, 1, 1, 1, e_fetch, "f_ovf");
`endif

    // u3 (MEM_LAT=3): launch lands 5 cycles after FETCH, IR_w only on the last wait cycle
    add(1, 1, 6'h00, 6'h20, 0, 0, 0, e_rst, "rst3");
    go (1, 6'h00, 6'h20, e_fetch, "f3");
    go (1, 6'h00, 6'h20, e_wait, "w3a");
    go (1, 6'h00, 6'h20, e_wait, "w3b");
    go (1, 6'h00, 6'h20, e_wait_ir, "w3ir");
    go (1, 6'h00, 6'h20, e_dec, "dec3");
    go (1, 6'h00, 6'h20, e_ex1(12'h020), "st3");
    add(1, 0, 6'h00, 6'h20, 1, 0, 0, e_fetch, "ret3");
    // reset mid MEMWAIT count, counter restarts
    go (1, 6'h00, 6'h25, e_wait, "w3c");
    add(1, 1, 6'h00, 6'h25, 0, 0, 0, e_rst, "rst_mw");
    go (1, 6'h00, 6'h25, e_fetch, "f3r");
    go (1, 6'h00, 6'h25, e_wait, "w3d");
    go (1, 6'h00, 6'h25, e_wait, "w3e");
    go (1, 6'h00, 6'h25, e_wait_ir, "w3ir2");
    go (1, 6'h00, 6'h25, e_dec, "dec3r");
    go (1, 6'h00, 6'h25, e_ex1(12'h025), "st3r");
    add(1, 0, 6'h00, 6'h25, 1, 0, 0, e_fetch, "ret3r");
`ifdef FETCH_EXC_CTRL_EXC_EN
    // illegal op: EXC_MEM held three cycles, then reset during a second EXC_MEM count
    go (1, 6'h3D, fi, e_wait, "x3w1");
    go (1, 6'h3D, fi, e_wait, "x3w2");
    go (1, 6'h3D, fi, e_wait_ir, "x3ir");
    go (1, 6'h3D, fi, e_dec, "x3dec");
    go (1, 6'h3D, fi, e_save, "x3sv");
    go (1, 6'h3D, fi, e_emem(2'b00), "x3em1");
    go (1, 6'h3D, fi, e_emem(2'b00), "x3em2");
    go (1, 6'h3D, fi, e_emem(2'b00), "x3em3");
    go (1, 6'h3D, fi, e_load, "x3ld");
    go (1, 6'h3D, fi, e_fetch, "x3f");
    go (1, 6'h3D, fi, e_wait, "y3w1");
    go (1, 6'h3D, fi, e_wait, "y3w2");
    go (1, 6'h3D, fi, e_wait_ir, "y3ir");
    go (1, 6'h3D, fi, e_dec, "y3dec");
    go (1, 6'h3D, fi, e_save, "y3sv");
    go (1, 6'h3D, fi, e_emem(2'b00), "y3em1");
    add(1, 1, 6'h3D, fi, 0, 0, 0, e_rst, "rst_em3");
    go (1, 6'h3D, fi, e_fetch, "y3f");
`endif

    // ---------------- driver + checker loop ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      opcode    = vecs[i].opc;
      funct     = vecs[i].fn;
      exec_done = vecs[i].done;
      ovf       = vecs[i].ovf;
      div0      = vecs[i].div0;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got  = vecs[i].sel ? act3 : act1;
      want = exp_q.pop_front();
      chk(got, want, vecs[i].tag);
    end

    // ---------------- reset-state check on both instances ----------------
    @(negedge clk);
    rst       = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    exec_done = 1'b0;
    ovf       = 1'b0;
    div0      = 1'b0;
    exp_q.push_back(e_rst);
    exp_q.push_back(e_rst);
    @(posedge clk);
    #1;
    chk(act1, exp_q.pop_front(), "rst_st1");
    chk(act3, exp_q.pop_front(), "rst_st3");

    // ---------------- expired-wait check (MEM_LAT=3 and MEM_LAT=1) ----------------
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(e_fetch);
    exp_q.push_back(e_fetch);
    @(posedge clk);
    #1;
    chk(act3, exp_q.pop_front(), "xw_f3");
    chk(act1, exp_q.pop_front(), "xw_f1");
    @(negedge clk);
    exp_q.push_back(e_wait);
    exp_q.push_back(e_wait_ir);
    @(posedge clk);
    #1;
    chk(act3, exp_q.pop_front(), "xw_w3a");
    chk(act1, exp_q.pop_front(), "xw_ir1");
    @(negedge clk);
    exp_q.push_back(e_wait);
    @(posedge clk);
    #1;
    chk(act3, exp_q.pop_front(), "xw_w3b");
    @(negedge clk);
    exp_q.push_back(e_wait_ir);
    @(posedge clk);
    #1;
    chk(act3, exp_q.pop_front(), "xw_ir3");
    @(negedge clk);
    exp_q.push_back(e_dec);
    @(posedge clk);
    #1;
    chk(act3, exp_q.pop_front(), "xw_dec3");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
